// File: rtl/pkg_cpu_typedefs.sv
// Shared types and constants for the memory bus arbiter.
package pkg_cpu_typedefs;

    // Arbiter ownership state: free arbitration or a DMA-held burst.
    typedef enum logic {
        ARB_FREE     = 1'b0,
        ARB_DMA_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mem_arb_sat_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    // Flag the saturation point so the parent never compares widths itself.
    always_comb begin
        at_max = (cnt == W'(MAX));
    end

    // Count up to MAX and hold there until cleared.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU (fixed priority) and a DMA/debug
// requester. DMA forward progress is guaranteed by a starvation counter, and
// DMA may hold the bus for bursts of at most LOCK_MAX grants.
//
// Handshake: a requester holds x_req until x_gnt is seen high in the same
// cycle; the access is performed in that cycle. Reads return x_rdata with
// x_rvalid exactly one cycle after the grant; writes return nothing.
module mem_bus_arbiter
    import pkg_cpu_typedefs::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr,
    input  logic [DATA_WIDTH-1:0]         cpu_wdata,
    output logic                          cpu_gnt,
    output logic                          cpu_rvalid,
    output logic [DATA_WIDTH-1:0]         cpu_rdata,
    input  logic                          dma_req,
    input  logic                          dma_we,
    input  logic [ADDR_WIDTH-1:0]         dma_addr,
    input  logic [DATA_WIDTH-1:0]         dma_wdata,
    input  logic                          dma_lock,
    output logic                          dma_gnt,
    output logic                          dma_rvalid,
    output logic [DATA_WIDTH-1:0]         dma_rdata,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wd,
    input  logic [DATA_WIDTH-1:0]         mem_rd,
    output logic                          dbg_state,
    output logic [$clog2(MAX_WAIT+1)-1:0] dbg_starve_cnt,
    output logic [$clog2(LOCK_MAX+1)-1:0] dbg_lock_cnt
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    arb_state_t    state_q, state_d;
    logic          force_cpu_q, force_cpu_d;
    logic [SW-1:0] starve_cnt;
    logic          starve_at_max;
    logic [LW-1:0] lock_cnt;
    logic          lock_at_max;
    logic          burst_last;

    // lock_cnt counts DMA grants already taken in this burst; the grant that
    // brings it to LOCK_MAX is the last one, so a burst is exactly LOCK_MAX long.
    assign burst_last = (lock_cnt == LW'(LOCK_MAX - 1));

    // State register plus the one-cycle CPU priority flag after a forced release.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ARB_FREE;
            force_cpu_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            force_cpu_q <= force_cpu_d;
        end
    end

    // Grants and next state; grants are held off while reset is asserted.
    always_comb begin
        dma_gnt     = 1'b0;
        cpu_gnt     = 1'b0;
        state_d     = state_q;
        force_cpu_d = 1'b0;
        if (sys_rst_n) begin
            case (state_q)
                ARB_FREE: begin
                    dma_gnt = dma_req & (!cpu_req | (starve_at_max & !force_cpu_q));
                    cpu_gnt = cpu_req & !dma_gnt;
                    if (dma_gnt && dma_lock) begin
                        if (burst_last) begin
                            force_cpu_d = 1'b1;
                        end else begin
                            state_d = ARB_DMA_LOCK;
                        end
                    end
                end
                ARB_DMA_LOCK: begin
                    dma_gnt = dma_req;
                    if (!dma_lock || !dma_req) begin
                        state_d = ARB_FREE;
                    end else if (burst_last || lock_at_max) begin
                        state_d     = ARB_FREE;
                        force_cpu_d = 1'b1;
                    end
                end
                default: state_d = ARB_FREE;
            endcase
        end
    end

    // Memory port follows the granted requester, and is all-zero when idle.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (dma_gnt) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_wd   = dma_wdata;
        end else if (cpu_gnt) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wdata;
        end
    end

    // DMA starvation tracking: counts denied request cycles.
    mem_arb_sat_cnt #(.MAX(MAX_WAIT), .W(SW)) u_starve_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (dma_req & !dma_gnt),
        .clr       (dma_gnt | !dma_req),
        .cnt       (starve_cnt),
        .at_max    (starve_at_max)
    );

    // Burst length tracking: runs only while the next state is the lock.
    mem_arb_sat_cnt #(.MAX(LOCK_MAX), .W(LW)) u_lock_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (state_d == ARB_DMA_LOCK),
        .clr       (state_d == ARB_FREE),
        .cnt       (lock_cnt),
        .at_max    (lock_at_max)
    );

    // Registered read return, one cycle after a read grant.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & !cpu_we;
            dma_rvalid <= dma_gnt & !dma_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem_rd;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_rd;
            end
        end
    end

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt;
    assign dbg_lock_cnt   = lock_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (MAX_WAIT = 4, LOCK_MAX = 8).
module tb_mem_bus_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        dbg_state;
    logic [2:0]  dbg_starve_cnt;
    logic [3:0]  dbg_lock_cnt;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];

    mem_bus_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_WAIT   (4),
        .LOCK_MAX   (8)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_lock       (dma_lock),
        .dma_gnt        (dma_gnt),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wd         (mem_wd),
        .mem_rd         (mem_rd),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt),
        .dbg_lock_cnt   (dbg_lock_cnt)
    );

    // Clock and watchdog.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_cpu_read();
        check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        if (exp_q.size() == 0) begin
            check("cpu_exp_q_empty", 32'd0, 32'd1);
        end else begin
            check("cpu_rdata", cpu_rdata, exp_q.pop_front());
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        dma_req  = 1'b0;
        dma_we   = 1'b0;
        dma_lock = 1'b0;
    endtask

    logic exp_cg[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_dg[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   exp_sc[6] = '{1, 2, 3, 4, 0, 1};

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        sys_rst_n = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h10;
        cpu_wdata = 32'h0;
        dma_req   = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 32'h40;
        dma_wdata = 32'h0;
        dma_lock  = 1'b1;
        mem_rd    = 32'hFFFF_FFFF;

        // Reset with both requesters active: everything held at zero.
        tick();
        tick();
        #1;
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dma_rdata", dma_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_starve", 32'(dbg_starve_cnt), 32'd0);
        check("rst_lock", 32'(dbg_lock_cnt), 32'd0);
        idle();
        sys_rst_n = 1'b1;
        tick();

        // CPU reads, back to back, no DMA.
        cpu_req  = 1'b1;
        cpu_addr = 32'h10;
        mem_rd   = 32'hDEAD_BEEF;
        #1;
        check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rd_mem_addr", mem_addr, 32'h10);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        check_cpu_read();
        check("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
        cpu_addr = 32'h14;
        mem_rd   = 32'hCAFE_F00D;
        #1;
        check("rd2_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("rd2_mem_addr", mem_addr, 32'h14);
        exp_q.push_back(32'hCAFE_F00D);
        tick();
        check_cpu_read();
        cpu_req = 1'b0;
        tick();
        check("rd_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        check("rd_rdata_hold", cpu_rdata, 32'hCAFE_F00D);

        // Starvation: CPU wins MAX_WAIT times, then DMA, then CPU again.
        cpu_req  = 1'b1;
        cpu_addr = 32'h44;
        dma_req  = 1'b1;
        dma_addr = 32'h40;
        mem_rd   = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("stv_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(exp_cg[i]));
            check($sformatf("stv_dma_gnt[%0d]", i), 32'(dma_gnt), 32'(exp_dg[i]));
            check($sformatf("stv_mem_addr[%0d]", i), mem_addr, exp_dg[i] ? 32'h40 : 32'h44);
            tick();
            check($sformatf("stv_cnt[%0d]", i), 32'(dbg_starve_cnt), 32'(exp_sc[i]));
            check($sformatf("stv_dma_rvalid[%0d]", i), 32'(dma_rvalid), 32'(exp_dg[i]));
            if (exp_dg[i]) begin
                check("stv_dma_rdata", dma_rdata, 32'h1234_5678);
            end
        end
        idle();
        tick();
        check("stv_cnt_clear", 32'(dbg_starve_cnt), 32'd0);

        // Locked burst: exactly LOCK_MAX DMA grants, then CPU is served.
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        dma_addr = 32'h80;
        cpu_addr = 32'h84;
        for (int i = 0; i < 9; i++) begin
            if (i == 1) cpu_req = 1'b1;
            #1;
            check($sformatf("lck_dma_gnt[%0d]", i), 32'(dma_gnt), (i < 8) ? 32'd1 : 32'd0);
            check($sformatf("lck_cpu_gnt[%0d]", i), 32'(cpu_gnt), (i == 8) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("lck_cnt[%0d]", i), 32'(dbg_lock_cnt), (i < 7) ? 32'(i + 1) : 32'd0);
            check($sformatf("lck_state[%0d]", i), 32'(dbg_state), (i < 7) ? 32'd1 : 32'd0);
        end
        idle();
        tick();

        // CPU write against a DMA read: CPU wins, no read data returned.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h20;
        cpu_wdata = 32'h5A5A_5A5A;
        dma_req   = 1'b1;
        dma_addr  = 32'h30;
        #1;
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", mem_addr, 32'h20);
        check("wr_mem_wd", mem_wd, 32'h5A5A_5A5A);
        check("wr_dma_gnt", 32'(dma_gnt), 32'd0);
        check("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        idle();
        check("wr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("wr_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("wr_starve", 32'(dbg_starve_cnt), 32'd1);
        tick();

        // Reset pulsed during the third cycle of a locked burst.
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        dma_addr = 32'h100;
        mem_rd   = 32'h0BAD_F00D;
        tick();
        tick();
        check("rml_state_pre", 32'(dbg_state), 32'd1);
        check("rml_dma_rvalid_pre", 32'(dma_rvalid), 32'd1);
        check("rml_dma_rdata_pre", dma_rdata, 32'h0BAD_F00D);
        #1;
        check("rml_dma_gnt_pre", 32'(dma_gnt), 32'd1);
        cpu_req   = 1'b1;
        cpu_addr  = 32'h10;
        mem_rd    = 32'h600D_CAFE;
        sys_rst_n = 1'b0;
        #1;
        check("rml_state", 32'(dbg_state), 32'd0);
        check("rml_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rml_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rml_dma_rdata", dma_rdata, 32'd0);
        check("rml_lock_cnt", 32'(dbg_lock_cnt), 32'd0);
        check("rml_cpu_gnt_in_rst", 32'(cpu_gnt), 32'd0);
        #1;
        sys_rst_n = 1'b1;
        #1;
        check("rml_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("rml_dma_gnt_post", 32'(dma_gnt), 32'd0);
        check("rml_mem_addr", mem_addr, 32'h10);
        exp_q.push_back(32'h600D_CAFE);
        tick();
        check_cpu_read();
        idle();
        tick();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
